// File: rtl/cb_config_chain.sv
// Connection-block configuration chain tile.
//   A serial frame is shifted through an internal register (SHIFT_W bits per
//   enabled cycle) and committed into a shadow register that drives the
//   connection-block switches. The commit is refused unless a complete frame
//   has been shifted since the last commit, and, when PARITY_EN is set, unless
//   its even parity matches set_par.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   cen                  shift enable
//   shift_in/shift_out   chain data from upstream / to downstream tile
//   set_in, set_par      one-cycle commit request, expected frame parity
//   conf_out             committed configuration
//   frame_full           a full frame has been shifted since the last commit/reset
//   loaded               at least one commit has been accepted since reset
//   err                  sticky flag, set by a rejected commit, cleared by an accepted one
module cb_config_chain #(
  parameter int unsigned CONF_W    = 64,
  parameter int unsigned SHIFT_W   = 1,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cen,
  input  logic [SHIFT_W-1:0] shift_in,
  output logic [SHIFT_W-1:0] shift_out,
  input  logic               set_in,
  input  logic               set_par,
  output logic [CONF_W-1:0]  conf_out,
  output logic               frame_full,
  output logic               loaded,
  output logic               err
);

  localparam int unsigned NBEATS = CONF_W / SHIFT_W;
  localparam int unsigned CNT_W  = $clog2(NBEATS + 1);

  if (CONF_W % SHIFT_W != 0) begin : g_bad_width
    $error("CONF_W must be a multiple of SHIFT_W");
  end

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } state_e;

  logic [CONF_W-1:0] sreg_q, sreg_d;
  logic [CONF_W-1:0] conf_q, conf_d;
  logic [CONF_W-1:0] shifted;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              par_q, par_d;
  logic              loaded_q, loaded_d;
  logic              err_q, err_d;
  logic              accept;
  state_e            state;

  // A single-beat frame replaces the whole register on each shift.
  if (NBEATS == 1) begin : g_one_beat
    assign shifted = shift_in;
  end else begin : g_multi_beat
    assign shifted = {sreg_q[CONF_W-SHIFT_W-1:0], shift_in};
  end

  // Frame state is a pure function of the beat counter, so the counter itself
  // is the state register and the enum is decoded from it.
  always_comb begin
    state = PARTIAL;
    if (cnt_q == '0) begin
      state = EMPTY;
    end else if (cnt_q == CNT_W'(NBEATS)) begin
      state = FULL;
    end
  end

  assign accept = set_in && (state == FULL) && (!PARITY_EN || (par_q == set_par));

  always_comb begin
    sreg_d   = sreg_q;
    par_d    = par_q;
    cnt_d    = cnt_q;
    conf_d   = conf_q;
    loaded_d = loaded_q;
    err_d    = err_q;

    if (cen) begin
      sreg_d = shifted;
      // Parity follows the register: add incoming bits, drop outgoing bits.
      par_d  = par_q ^ (^shift_in) ^ (^sreg_q[CONF_W-1 -: SHIFT_W]);
      if (state != FULL) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // Any commit request restarts the frame count; a same-cycle shift is
    // the first beat of the new frame.
    if (set_in) begin
      cnt_d = cen ? CNT_W'(1) : '0;
      if (accept) begin
        conf_d   = sreg_q;
        loaded_d = 1'b1;
        err_d    = 1'b0;
      end else begin
        err_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q   <= '0;
      par_q    <= 1'b0;
      cnt_q    <= '0;
      conf_q   <= '0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sreg_q   <= sreg_d;
      par_q    <= par_d;
      cnt_q    <= cnt_d;
      conf_q   <= conf_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
    end
  end

  assign shift_out  = sreg_q[CONF_W-1 -: SHIFT_W];
  assign conf_out   = conf_q;
  assign frame_full = (state == FULL);
  assign loaded     = loaded_q;
  assign err        = err_q;

endmodule

// File: tb/tb_cb_config_chain.sv
// Bench for cb_config_chain with CONF_W=8, SHIFT_W=2, PARITY_EN=1:
// directed vector table, hand-written shift_out / async reset sequences,
// and random traffic against a beat-history reference model.
module tb_cb_config_chain;

  logic       clk;
  logic       rst_n;
  logic       cen;
  logic [1:0] shift_in;
  logic [1:0] shift_out;
  logic       set_in;
  logic       set_par;
  logic [7:0] conf_out;
  logic       frame_full;
  logic       loaded;
  logic       err;

  int total;
  int bad;

  cb_config_chain #(
    .CONF_W   (8),
    .SHIFT_W  (2),
    .PARITY_EN(1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cen       (cen),
    .shift_in  (shift_in),
    .shift_out (shift_out),
    .set_in    (set_in),
    .set_par   (set_par),
    .conf_out  (conf_out),
    .frame_full(frame_full),
    .loaded    (loaded),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       cen;
    logic [1:0] sin;
    logic       set;
    logic       par;
    logic [7:0] conf;
    logic       full;
    logic       ld;
    logic       err;
    logic [1:0] sout;
  } vec_t;

  vec_t vq[$];

  // Reference model: recent beats (oldest first), beats since last commit.
  logic [1:0] hist[$];
  int         m_beats;
  logic [7:0] m_conf;
  logic       m_ld;
  logic       m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [12:0] obs();
    return {conf_out, frame_full, loaded, err, shift_out};
  endfunction

  task automatic add(input logic c, input logic [1:0] s, input logic st, input logic p,
                     input logic [7:0] cf, input logic fu, input logic l, input logic e,
                     input logic [1:0] so);
    vec_t v;
    v.cen = c; v.sin = s; v.set = st; v.par = p;
    v.conf = cf; v.full = fu; v.ld = l; v.err = e; v.sout = so;
    vq.push_back(v);
  endtask

  // Drive inputs for one cycle; returns 1 time unit after the rising edge.
  task automatic step(input logic c, input logic [1:0] s, input logic st, input logic p);
    cen = c; shift_in = s; set_in = st; set_par = p;
    @(posedge clk);
    #1;
    cen = 1'b0; shift_in = 2'd0; set_in = 1'b0; set_par = 1'b0;
  endtask

  function automatic logic [7:0] m_frame();
    return {hist[0], hist[1], hist[2], hist[3]};
  endfunction

  task automatic m_reset();
    hist.delete();
    repeat (4) hist.push_back(2'd0);
    m_beats = 0; m_conf = 8'h00; m_ld = 1'b0; m_err = 1'b0;
  endtask

  task automatic m_cycle(input logic c, input logic [1:0] s, input logic st, input logic p);
    logic [7:0] f;
    f = m_frame();
    if (st) begin
      if (m_beats >= 4 && ((^f) == p)) begin
        m_conf = f; m_ld = 1'b1; m_err = 1'b0;
      end else begin
        m_err = 1'b1;
      end
      m_beats = c ? 1 : 0;
    end else if (c) begin
      m_beats++;
    end
    if (c) begin
      hist.push_back(s);
      void'(hist.pop_front());
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cen = 1'b0; shift_in = 2'd0; set_in = 1'b0; set_par = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    do_reset();
    chk("reset_state", 32'(obs()), 32'(13'h0000));

    // cen sin set par | conf full ld err sout (after the edge)
    // three beats then commit: rejected
    add(1'b1, 2'd2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0);
    add(1'b1, 2'd3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0);
    add(1'b1, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0);
    add(1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0);
    // full frame B1, even parity: accepted
    add(1'b1, 2'd2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd2);
    add(1'b1, 2'd3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd3);
    add(1'b1, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0);
    add(1'b1, 2'd1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd2);
    add(1'b0, 2'd0, 1'b1, 1'b0, 8'hB1, 1'b0, 1'b1, 1'b0, 2'd2);
    // full frame B1 with wrong parity: rejected, conf held
    add(1'b1, 2'd2, 1'b0, 1'b0, 8'hB1, 1'b0, 1'b1, 1'b0, 2'd3);
    add(1'b1, 2'd3, 1'b0, 1'b0, 8'hB1, 1'b0, 1'b1, 1'b0, 2'd0);
    add(1'b1, 2'd0, 1'b0, 1'b0, 8'hB1, 1'b0, 1'b1, 1'b0, 2'd1);
    add(1'b1, 2'd1, 1'b0, 1'b0, 8'hB1, 1'b1, 1'b1, 1'b0, 2'd2);
    add(1'b0, 2'd0, 1'b1, 1'b1, 8'hB1, 1'b0, 1'b1, 1'b1, 2'd2);
    // six beats, then commit with a same-cycle shift: frame 49 accepted
    add(1'b1, 2'd3, 1'b0, 1'b0, 8'hB1, 1'b0, 1'b1, 1'b1, 2'd3);
    add(1'b1, 2'd3, 1'b0, 1'b0, 8'hB1, 1'b0, 1'b1, 1'b1, 2'd0);
    add(1'b1, 2'd1, 1'b0, 1'b0, 8'hB1, 1'b0, 1'b1, 1'b1, 2'd1);
    add(1'b1, 2'd0, 1'b0, 1'b0, 8'hB1, 1'b1, 1'b1, 1'b1, 2'd3);
    add(1'b1, 2'd2, 1'b0, 1'b0, 8'hB1, 1'b1, 1'b1, 1'b1, 2'd3);
    add(1'b1, 2'd1, 1'b0, 1'b0, 8'hB1, 1'b1, 1'b1, 1'b1, 2'd1);
    add(1'b1, 2'd0, 1'b1, 1'b1, 8'h49, 1'b0, 1'b1, 1'b0, 2'd0);
    // count restarted at 1: three more beats reach FULL
    add(1'b1, 2'd0, 1'b0, 1'b0, 8'h49, 1'b0, 1'b1, 1'b0, 2'd2);
    add(1'b1, 2'd0, 1'b0, 1'b0, 8'h49, 1'b0, 1'b1, 1'b0, 2'd1);
    add(1'b1, 2'd0, 1'b0, 1'b0, 8'h49, 1'b1, 1'b1, 1'b0, 2'd0);
    // set held two cycles: first accepted, second rejected
    add(1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0);
    add(1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 2'd0);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].cen, vq[i].sin, vq[i].set, vq[i].par);
      chk($sformatf("vec%0d", i), 32'(obs()),
          32'({vq[i].conf, vq[i].full, vq[i].ld, vq[i].err, vq[i].sout}));
    end

    // Commit B1, then shift 5A: old frame drains out, conf untouched.
    step(1'b1, 2'd2, 1'b0, 1'b0);
    step(1'b1, 2'd3, 1'b0, 1'b0);
    step(1'b1, 2'd0, 1'b0, 1'b0);
    step(1'b1, 2'd1, 1'b0, 1'b0);
    step(1'b0, 2'd0, 1'b1, 1'b0);
    chk("commit_b1", 32'(conf_out), 32'(8'hB1));
    begin
      logic [1:0] exp_out[4];
      logic [1:0] beat_in[4];
      exp_out = '{2'd2, 2'd3, 2'd0, 2'd1};
      beat_in = '{2'd1, 2'd1, 2'd2, 2'd2};
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("drain_out%0d", i), 32'(shift_out), 32'(exp_out[i]));
        step(1'b1, beat_in[i], 1'b0, 1'b0);
        chk($sformatf("drain_conf%0d", i), 32'(conf_out), 32'(8'hB1));
      end
    end

    // Asynchronous reset mid-frame.
    step(1'b1, 2'd1, 1'b0, 1'b0);
    step(1'b1, 2'd2, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_outs", 32'(obs()), 32'(13'h0000));
    chk("async_rst_cnt", 32'(dut.cnt_q), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_outs", 32'(obs()), 32'(13'h0000));
    step(1'b1, 2'd2, 1'b0, 1'b0);
    step(1'b1, 2'd3, 1'b0, 1'b0);
    step(1'b1, 2'd0, 1'b0, 1'b0);
    step(1'b1, 2'd1, 1'b0, 1'b0);
    step(1'b0, 2'd0, 1'b1, 1'b0);
    chk("reload_after_rst", 32'(obs()), 32'({8'hB1, 1'b0, 1'b1, 1'b0, 2'd2}));

    // Random traffic against the model.
    do_reset();
    m_reset();
    for (int n = 0; n < 400; n++) begin
      logic       c, st, p;
      logic [1:0] s;
      c  = ($urandom_range(0, 3) != 0);
      s  = 2'($urandom_range(0, 3));
      st = ($urandom_range(0, 5) == 0);
      p  = ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1)) : ^m_frame();
      step(c, s, st, p);
      m_cycle(c, s, st, p);
      chk($sformatf("rand%0d", n), 32'(obs()),
          32'({m_conf, (m_beats >= 4), m_ld, m_err, hist[0]}));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cb_config_chain.md
CB_CONFIG_CHAIN -- requirements
Module: cb_config_chain

Interface
REQ-001 Parameter CONF_W, default 64: configuration frame width in bits; the block SHALL require CONF_W % SHIFT_W == 0.
REQ-002 Parameter SHIFT_W, default 1: chain bits shifted per enabled cycle; the block SHALL define NBEATS = CONF_W/SHIFT_W.
REQ-003 Parameter PARITY_EN, default 1: 1 = commit gated by parity check, 0 = parity ignored.
REQ-004 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port cen, input, 1: shift enable.
REQ-007 Port shift_in, input, SHIFT_W: chain data in, from the upstream tile.
REQ-008 Port shift_out, output, SHIFT_W: chain data out, to the downstream tile.
REQ-009 Port set_in, input, 1: one-cycle commit request.
REQ-010 Port set_par, input, 1: expected even parity of the frame, sampled with set_in.
REQ-011 Port conf_out, output, CONF_W: committed (shadow) configuration driving the connection-block switches.
REQ-012 Port frame_full, output, 1: at least NBEATS beats shifted since the last commit or reset.
REQ-013 Port loaded, output, 1: at least one successful commit since reset.
REQ-014 Port err, output, 1: sticky error flag for a rejected commit.

Function
REQ-015 Internal shift register sreg[CONF_W-1:0] SHALL, when cen=1, load {sreg[CONF_W-SHIFT_W-1:0], shift_in}; when cen=0 it holds.
REQ-016 shift_out SHALL equal sreg[CONF_W-1 -: SHIFT_W] combinationally from the register, giving NBEATS enabled cycles of latency from shift_in to shift_out.
REQ-017 Running parity register par SHALL track XOR of all sreg bits.
REQ-018 par SHALL be updated incrementally on each enabled shift: par ^ ^shift_in ^ ^(outgoing slice).
REQ-019 Beat counter cnt, width clog2(NBEATS+1), SHALL increment on each cen=1 cycle and saturate at NBEATS; extra beats from chained tiles are legal pass-through.
REQ-020 State SHALL be EMPTY (cnt=0), PARTIAL (0<cnt<NBEATS) or FULL (cnt=NBEATS); frame_full=1 exactly in FULL.
REQ-021 A commit is accepted when set_in=1, state is FULL, and (PARITY_EN=0 or par==set_par).
REQ-022 On an accepted commit, conf_out SHALL take the pre-shift sreg value on the next rising edge, loaded SHALL be set and err SHALL be cleared.
REQ-023 On a rejected commit (not FULL, or parity mismatch), conf_out SHALL hold, err SHALL be set, and loaded SHALL hold.
REQ-024 On any set_in=1 cycle, accepted or rejected, cnt SHALL clear to 0, or to 1 if cen=1 in the same cycle.
REQ-025 When set_in and cen are both 1 in one cycle, the commit SHALL use pre-shift contents and the shift SHALL still occur.
REQ-026 conf_out SHALL change only on an accepted commit or reset; it SHALL never reflect partial shifts.
REQ-027 set_in held high for multiple cycles SHALL be treated as repeated requests; the second and later requests are rejected, since cnt is no longer FULL.

Reset
REQ-028 rst_n=0 SHALL immediately clear sreg, par, cnt, conf_out (all switches open), loaded and err, independent of clk.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame; after release, state is EMPTY and shift_out=0.
REQ-030 Deassertion of rst_n is externally synchronised; the first rising edge after release SHALL behave as a normal cycle.

Verification (CONF_W=8, SHIFT_W=2, PARITY_EN=1)
REQ-031 Shift 2'b10,2'b11,2'b00,2'b01 with cen=1, then set_in=1 with set_par=0 -> frame_full=1 before the set; next cycle conf_out=8'hB1, loaded=1, err=0.
REQ-032 Shift three beats only, then set_in=1 -> err=1, conf_out unchanged at 8'h00, frame_full=0 afterward.
REQ-033 Full frame 8'hB1 with set_par=1 -> err=1, conf_out keeps its previous value.
REQ-034 Load 8'hB1, commit, then shift 8'h5A in 4 beats -> shift_out emits 2'b10,2'b11,2'b00,2'b01 on beats 1-4, and conf_out stays 8'hB1 throughout.
REQ-035 Drop rst_n after 2 beats with conf_out=8'hB1 -> conf_out, loaded, err and cnt read 0 asynchronously; a fresh 4-beat load with commit succeeds.
REQ-036 Six enabled beats, then set_in and cen both high -> commit of the last four beats' frame succeeds and cnt=1 the next cycle.
